// File: rtl/AHB_package.sv
// Shared AHB encodings, the slave address map and the burst length helper used by
// the per-master request generators.
package AHB_package;

    localparam int unsigned MAP_SLAVES = 3;

    typedef enum logic [1:0] {
        TransIdle   = 2'd0,
        TransBusy   = 2'd1,
        TransNonseq = 2'd2,
        TransSeq    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        BurstSingle = 3'd0,
        BurstIncr   = 3'd1,
        BurstWrap4  = 3'd2,
        BurstIncr4  = 3'd3,
        BurstWrap8  = 3'd4,
        BurstIncr8  = 3'd5,
        BurstWrap16 = 3'd6,
        BurstIncr16 = 3'd7
    } hburst_e;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StXfer,
        StErr1,
        StErr2
    } state_e;

    // 256 MB regions at the bottom of the map; everything from 0x3000_0000 up is unmapped.
    localparam logic [31:0] SLAVE_BASE [MAP_SLAVES] = '{
        32'h0000_0000, 32'h1000_0000, 32'h2000_0000
    };
    localparam logic [31:0] SLAVE_MASK [MAP_SLAVES] = '{
        32'hF000_0000, 32'hF000_0000, 32'hF000_0000
    };

    // Undefined-length INCR is arbitrated beat by beat, so it counts as a single.
    function automatic int unsigned burst_len(input logic [2:0] hburst);
        int unsigned len;
        case (hburst_e'(hburst))
            BurstWrap4,  BurstIncr4:  len = 4;
            BurstWrap8,  BurstIncr8:  len = 8;
            BurstWrap16, BurstIncr16: len = 16;
            default:                  len = 1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ahb_addr_decoder.sv
// Combinational address decoder: one-hot slave hit plus a miss flag.
module ahb_addr_decoder
    import AHB_package::*;
#(
    parameter int unsigned SLAVE_NUM  = 3,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [SLAVE_NUM-1:0]  hit_o,
    output logic                  miss_o
);

    always_comb begin
        hit_o = '0;
        // Walk downwards so the lowest matching index overwrites any higher one.
        for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
            if ((addr_i & SLAVE_MASK[i][ADDR_WIDTH-1:0]) == SLAVE_BASE[i][ADDR_WIDTH-1:0]) begin
                hit_o    = '0;
                hit_o[i] = 1'b1;
            end
        end
        miss_o = ~|hit_o;
    end

endmodule

// File: rtl/ahb_master_req_gen.sv
// Per-master AHB request generator: decodes the target slave, requests its arbiter,
// counts burst beats for hlast and stalls the master until the grant arrives.
module ahb_master_req_gen
    import AHB_package::*;
#(
    parameter int unsigned SLAVE_NUM  = 3,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BEAT_CNT_W = 4
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hburst,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [SLAVE_NUM-1:0]  hgrant,
    output logic [SLAVE_NUM-1:0]  hreq,
    output logic [SLAVE_NUM-1:0]  hlast,
    output logic                  hready_out,
    output logic                  hresp,
    output logic [SLAVE_NUM-1:0]  slave_sel
);

    state_e                state_q, state_d;
    logic [SLAVE_NUM-1:0]  slave_sel_q, slave_sel_d;
    logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
    logic [BEAT_CNT_W-1:0] last_q, last_d;

    logic [SLAVE_NUM-1:0]  hit;
    logic                  miss;
    logic                  granted;
    logic                  beat_acc;
    logic                  last_beat;

    ahb_addr_decoder #(
        .SLAVE_NUM  (SLAVE_NUM),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_decoder (
        .addr_i (haddr),
        .hit_o  (hit),
        .miss_o (miss)
    );

    assign slave_sel = slave_sel_q;

    always_comb begin
        state_d     = state_q;
        slave_sel_d = slave_sel_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        hreq        = '0;
        hlast       = '0;
        hready_out  = 1'b1;
        hresp       = 1'b0;
        // Grants from arbiters we are not targeting are masked off here.
        granted     = |(hgrant & slave_sel_q);
        beat_acc    = granted && ((htrans == TransNonseq) || (htrans == TransSeq));
        last_beat   = (cnt_q == last_q);

        unique case (state_q)
            StIdle: begin
                if (htrans == TransNonseq) begin
                    if (miss) begin
                        state_d = StErr1;
                    end else begin
                        slave_sel_d = hit;
                        last_d      = BEAT_CNT_W'(burst_len(hburst) - 1);
                        cnt_d       = '0;
                        state_d     = StReq;
                    end
                end
            end
            StReq, StXfer: begin
                hreq       = slave_sel_q;
                hready_out = granted;
                if (last_beat) begin
                    hlast = slave_sel_q;
                end
                if (granted && (state_q == StReq)) begin
                    state_d = StXfer;
                end
                if (beat_acc) begin
                    if (last_beat) begin
                        state_d     = StIdle;
                        slave_sel_d = '0;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + BEAT_CNT_W'(1);
                    end
                end
            end
            StErr1: begin
                hready_out = 1'b0;
                hresp      = 1'b1;
                state_d    = StErr2;
            end
            StErr2: begin
                hresp   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= StIdle;
            slave_sel_q <= '0;
            cnt_q       <= '0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            slave_sel_q <= slave_sel_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
        end
    end

endmodule

// File: tb/tb_ahb_master_req_gen.sv
// Directed self-checking bench for ahb_master_req_gen with hand-computed cycle tables.
module tb_ahb_master_req_gen;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_BUSY = 2'd1;
    localparam logic [1:0] T_NSEQ = 2'd2;
    localparam logic [1:0] T_SEQ  = 2'd3;

    logic        hclk;
    logic        hreset;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [31:0] haddr;
    logic [2:0]  hgrant;
    logic [2:0]  hreq;
    logic [2:0]  hlast;
    logic        hready_out;
    logic        hresp;
    logic [2:0]  slave_sel;

    int checks = 0;
    int errors = 0;

    ahb_master_req_gen #(
        .SLAVE_NUM  (3),
        .ADDR_WIDTH (32),
        .BEAT_CNT_W (4)
    ) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .htrans     (htrans),
        .hburst     (hburst),
        .haddr      (haddr),
        .hgrant     (hgrant),
        .hreq       (hreq),
        .hlast      (hlast),
        .hready_out (hready_out),
        .hresp      (hresp),
        .slave_sel  (slave_sel)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        hreset = 1'b1; htrans = T_IDLE; hburst = 3'd0; haddr = 32'h0; hgrant = 3'b000;
        step(); step();
        for (int r = 0; r < 2; r++) begin
            hreset = (r == 0);
            #1;
            checks++; if (hreq !== 3'b000) begin errors++;
                $display("FAIL reset_hreq[%0d]: got %b expected 000", r, hreq); end
            checks++; if (hlast !== 3'b000) begin errors++;
                $display("FAIL reset_hlast[%0d]: got %b expected 000", r, hlast); end
            checks++; if (slave_sel !== 3'b000) begin errors++;
                $display("FAIL reset_sel[%0d]: got %b expected 000", r, slave_sel); end
            checks++; if (hready_out !== 1'b1) begin errors++;
                $display("FAIL reset_hready[%0d]: got %b expected 1", r, hready_out); end
            checks++; if (hresp !== 1'b0) begin errors++;
                $display("FAIL reset_hresp[%0d]: got %b expected 0", r, hresp); end
            step();
        end
    endtask

    task automatic test_single();
        logic [2:0] er;
        haddr = 32'h1000_0040; hburst = 3'd0;
        for (int c = 0; c < 4; c++) begin
            htrans = (c < 3) ? T_NSEQ : T_IDLE;
            hgrant = (c == 2) ? 3'b010 : 3'b000;
            #1;
            er = (c == 1 || c == 2) ? 3'b010 : 3'b000;
            checks++; if (hreq !== er) begin errors++;
                $display("FAIL single_hreq c%0d: got %b expected %b", c, hreq, er); end
            checks++; if (hlast !== er) begin errors++;
                $display("FAIL single_hlast c%0d: got %b expected %b", c, hlast, er); end
            checks++; if (slave_sel !== er) begin errors++;
                $display("FAIL single_sel c%0d: got %b expected %b", c, slave_sel, er); end
            checks++; if (hready_out !== (c != 1)) begin errors++;
                $display("FAIL single_hready c%0d: got %b expected %b", c, hready_out, c != 1); end
            step();
        end
    endtask

    // Cycle 1 carries a grant for the wrong slave, which must not release the master.
    task automatic test_incr4();
        logic [1:0] tr [6] = '{T_NSEQ, T_NSEQ, T_NSEQ, T_SEQ, T_SEQ, T_SEQ};
        logic [2:0] g  [6] = '{3'b000, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001};
        logic       rq [6] = '{0, 1, 1, 1, 1, 1};
        logic       ls [6] = '{0, 0, 0, 0, 0, 1};
        logic       rd [6] = '{1, 0, 1, 1, 1, 1};
        haddr = 32'h0000_0100; hburst = 3'd3;
        for (int c = 0; c < 6; c++) begin
            htrans = tr[c]; hgrant = g[c];
            #1;
            checks++; if (hreq !== (rq[c] ? 3'b001 : 3'b000)) begin errors++;
                $display("FAIL incr4_hreq c%0d: got %b expected %b", c, hreq, rq[c]); end
            checks++; if (hlast !== (ls[c] ? 3'b001 : 3'b000)) begin errors++;
                $display("FAIL incr4_hlast c%0d: got %b expected %b", c, hlast, ls[c]); end
            checks++; if (hready_out !== rd[c]) begin errors++;
                $display("FAIL incr4_hready c%0d: got %b expected %b", c, hready_out, rd[c]); end
            step();
        end
    endtask

    // Starts in the cycle right after the INCR4 last beat, so cycle 0 also sees hreq drop.
    task automatic test_back_to_back();
        logic [2:0] er;
        haddr = 32'h2000_0010; hburst = 3'd0;
        for (int c = 0; c < 4; c++) begin
            htrans = (c < 3) ? T_NSEQ : T_IDLE;
            hgrant = (c == 2) ? 3'b100 : 3'b000;
            #1;
            er = (c == 1 || c == 2) ? 3'b100 : 3'b000;
            checks++; if (hreq !== er) begin errors++;
                $display("FAIL b2b_hreq c%0d: got %b expected %b", c, hreq, er); end
            checks++; if (hlast !== er) begin errors++;
                $display("FAIL b2b_hlast c%0d: got %b expected %b", c, hlast, er); end
            checks++; if (slave_sel !== er) begin errors++;
                $display("FAIL b2b_sel c%0d: got %b expected %b", c, slave_sel, er); end
            checks++; if (hready_out !== (c != 1)) begin errors++;
                $display("FAIL b2b_hready c%0d: got %b expected %b", c, hready_out, c != 1); end
            step();
        end
    endtask

    // BUSY on cycle 4 and a grant drop on cycle 7 each hold the beat count.
    task automatic test_incr8_busy_stall();
        logic [1:0] tr [13] = '{T_NSEQ, T_NSEQ, T_NSEQ, T_SEQ, T_BUSY, T_SEQ, T_SEQ,
                                T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_IDLE};
        logic       g  [13] = '{0, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        logic       rq [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic       ls [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        logic       rd [13] = '{1, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
        haddr = 32'h2000_0000; hburst = 3'd5;
        for (int c = 0; c < 13; c++) begin
            htrans = tr[c]; hgrant = g[c] ? 3'b100 : 3'b000;
            #1;
            checks++; if (hreq !== (rq[c] ? 3'b100 : 3'b000)) begin errors++;
                $display("FAIL incr8_hreq c%0d: got %b expected %b", c, hreq, rq[c]); end
            checks++; if (hlast !== (ls[c] ? 3'b100 : 3'b000)) begin errors++;
                $display("FAIL incr8_hlast c%0d: got %b expected %b", c, hlast, ls[c]); end
            checks++; if (hready_out !== rd[c]) begin errors++;
                $display("FAIL incr8_hready c%0d: got %b expected %b", c, hready_out, rd[c]); end
            step();
        end
    endtask

    task automatic test_error();
        logic rd [4] = '{1, 0, 1, 1};
        logic rs [4] = '{0, 1, 1, 0};
        haddr = 32'h5000_0000; hburst = 3'd0; hgrant = 3'b111;
        for (int c = 0; c < 4; c++) begin
            htrans = (c == 0) ? T_NSEQ : T_IDLE;
            #1;
            checks++; if (hreq !== 3'b000) begin errors++;
                $display("FAIL err_hreq c%0d: got %b expected 000", c, hreq); end
            checks++; if (hresp !== rs[c]) begin errors++;
                $display("FAIL err_hresp c%0d: got %b expected %b", c, hresp, rs[c]); end
            checks++; if (hready_out !== rd[c]) begin errors++;
                $display("FAIL err_hready c%0d: got %b expected %b", c, hready_out, rd[c]); end
            step();
        end
        hgrant = 3'b000;
    endtask

    task automatic test_incr16();
        logic       exp_l;
        logic [2:0] exp_r;
        haddr = 32'h1000_0800; hburst = 3'd7;
        for (int c = 0; c < 19; c++) begin
            htrans = (c < 3) ? T_NSEQ : ((c < 18) ? T_SEQ : T_IDLE);
            hgrant = (c >= 2 && c <= 17) ? 3'b010 : 3'b000;
            #1;
            exp_r = (c >= 1 && c <= 17) ? 3'b010 : 3'b000;
            exp_l = (c == 17);
            checks++; if (hreq !== exp_r) begin errors++;
                $display("FAIL incr16_hreq c%0d: got %b expected %b", c, hreq, exp_r); end
            checks++; if (hlast !== (exp_l ? 3'b010 : 3'b000)) begin errors++;
                $display("FAIL incr16_hlast c%0d: got %b expected %b", c, hlast, exp_l); end
            checks++; if (hready_out !== (c != 1)) begin errors++;
                $display("FAIL incr16_hready c%0d: got %b expected %b", c, hready_out, c != 1); end
            checks++; if (slave_sel !== exp_r) begin errors++;
                $display("FAIL incr16_sel c%0d: got %b expected %b", c, slave_sel, exp_r); end
            step();
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [2:0] er;
        haddr = 32'h0000_0200; hburst = 3'd4;
        for (int c = 0; c < 4; c++) begin
            htrans = (c < 3) ? T_NSEQ : T_SEQ;
            hgrant = (c >= 2) ? 3'b001 : 3'b000;
            hreset = (c == 3);
            #1;
            checks++; if (hreq !== ((c >= 1) ? 3'b001 : 3'b000)) begin errors++;
                $display("FAIL wrap8_hreq c%0d: got %b", c, hreq); end
            step();
        end
        hreset = 1'b0; htrans = T_IDLE; hgrant = 3'b000;
        #1;
        checks++; if (hreq !== 3'b000) begin errors++;
            $display("FAIL rst_mid_hreq: got %b expected 000", hreq); end
        checks++; if (hlast !== 3'b000) begin errors++;
            $display("FAIL rst_mid_hlast: got %b expected 000", hlast); end
        checks++; if (slave_sel !== 3'b000) begin errors++;
            $display("FAIL rst_mid_sel: got %b expected 000", slave_sel); end
        checks++; if (hready_out !== 1'b1) begin errors++;
            $display("FAIL rst_mid_hready: got %b expected 1", hready_out); end
        step();
        haddr = 32'h2000_0010; hburst = 3'd0;
        for (int c = 0; c < 4; c++) begin
            htrans = (c < 3) ? T_NSEQ : T_IDLE;
            hgrant = (c == 2) ? 3'b100 : 3'b000;
            #1;
            er = (c == 1 || c == 2) ? 3'b100 : 3'b000;
            checks++; if (hreq !== er) begin errors++;
                $display("FAIL post_rst_hreq c%0d: got %b expected %b", c, hreq, er); end
            checks++; if (hlast !== er) begin errors++;
                $display("FAIL post_rst_hlast c%0d: got %b expected %b", c, hlast, er); end
            checks++; if (hready_out !== (c != 1)) begin errors++;
                $display("FAIL post_rst_hready c%0d: got %b expected %b", c, hready_out, c != 1);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_incr4();
        test_back_to_back();
        test_incr8_busy_stall();
        test_error();
        test_incr16();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
